// File: rtl/ca_egr_rcv_protocol_error_collector.sv
// ca_egr_rcv_protocol_error_collector: sticky/first-error/count collector for egress receive protocol errors (optional timestamp via CA_EGR_RCV_ERR_TIMESTAMP_EN)
module ca_egr_rcv_protocol_error_collector (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic [15:0] protocol_error,
  input  logic        protocol_error_ap_vld,
  input  logic [15:0] error_mask,
  input  logic        clear_req,
  input  logic [15:0] clear_bits,
  output logic [15:0] error_sticky,
  output logic [15:0] first_error,
  output logic [31:0] first_error_time,
  output logic [15:0] error_event_count,
  output logic        irq
);
  typedef enum logic {CLEAN, LATCHED} state_t;
  state_t      state_q;
  logic [15:0] sticky_q, first_q, count_q, masked, kept, sticky_d;
  logic [31:0] ftime_q, ts;
  logic        irq_q, evt, rearm;
`ifdef CA_EGR_RCV_ERR_TIMESTAMP_EN
  logic [31:0] ts_q;
  // free-running cycle counter used as the event timestamp
  always_ff @(posedge ap_clk) ts_q <= ap_rst ? 32'h0 : ts_q + 32'h1;
  assign ts = ts_q;
`else
  assign ts = 32'h0;
`endif
  // masked event, next sticky value and the re-arm condition
  always_comb begin
    masked   = protocol_error_ap_vld ? protocol_error & ~error_mask : 16'h0;
    evt      = |masked;
    kept     = clear_req ? sticky_q & ~clear_bits : sticky_q;
    sticky_d = kept | masked;
    rearm    = state_q == LATCHED && clear_req && kept == 16'h0 && evt;
  end
  // CLEAN/LATCHED FSM with registered sticky, count, first-error capture and irq
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q  <= CLEAN;
      sticky_q <= 16'h0;
      first_q  <= 16'h0;
      ftime_q  <= 32'h0;
      count_q  <= 16'h0;
      irq_q    <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
      count_q  <= (clear_req && clear_bits == 16'hFFFF) ? {15'h0, evt}
                : count_q + {15'h0, evt && count_q != 16'hFFFF};
      if ((state_q == CLEAN && evt) || rearm) begin
        state_q <= LATCHED;
        irq_q   <= 1'b1;
        first_q <= masked;
        ftime_q <= ts;
      end else if (state_q == LATCHED && sticky_d == 16'h0) begin
        state_q <= CLEAN;
        irq_q   <= 1'b0;
        first_q <= 16'h0;
        ftime_q <= 32'h0;
      end
    end
  end
  assign error_sticky      = sticky_q;
  assign first_error       = first_q;
  assign first_error_time  = ftime_q;
  assign error_event_count = count_q;
  assign irq               = irq_q;
endmodule

// File: tb/tb_ca_egr_rcv_protocol_error_collector.sv
// tb_ca_egr_rcv_protocol_error_collector: directed self-checking bench for the protocol error collector
module tb_ca_egr_rcv_protocol_error_collector;
`ifdef CA_EGR_RCV_ERR_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif
  logic        ap_clk = 1'b0, ap_rst = 1'b1;
  logic [15:0] protocol_error = '0, error_mask = '0, clear_bits = '0;
  logic        protocol_error_ap_vld = 1'b0, clear_req = 1'b0;
  logic [15:0] error_sticky, first_error, error_event_count;
  logic [31:0] first_error_time;
  logic        irq;
  logic [31:0] cyc = '0, t;
  int          tests = 0, fails = 0;

  ca_egr_rcv_protocol_error_collector dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .protocol_error(protocol_error), .protocol_error_ap_vld(protocol_error_ap_vld),
    .error_mask(error_mask), .clear_req(clear_req), .clear_bits(clear_bits),
    .error_sticky(error_sticky), .first_error(first_error),
    .first_error_time(first_error_time), .error_event_count(error_event_count),
    .irq(irq)
  );

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= ap_rst ? 32'h0 : cyc + 32'h1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
    protocol_error_ap_vld = 1'b0;
    clear_req = 1'b0;
  endtask

  task automatic ev(input logic [15:0] e);
    protocol_error = e;
    protocol_error_ap_vld = 1'b1;
    t = cyc;
    step();
  endtask

  task automatic clr(input logic [15:0] b);
    clear_bits = b;
    clear_req = 1'b1;
    step();
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_sticky"}, {16'h0, error_sticky}, 32'h0);
    chk({tag, "_first"}, {16'h0, first_error}, 32'h0);
    chk({tag, "_time"}, first_error_time, 32'h0);
    chk({tag, "_count"}, {16'h0, error_event_count}, 32'h0);
    chk({tag, "_irq"}, {31'h0, irq}, 32'h0);
  endtask

  initial begin
    step();
    step();
    all_zero("reset");
    ap_rst = 1'b0;
    for (int i = 0; i < 200 && cyc != 32'd100; i++) step();
    // single event at timestamp 100
    ev(16'h0041);
    chk("single_sticky", {16'h0, error_sticky}, 32'h0041);
    chk("single_first", {16'h0, first_error}, 32'h0041);
    chk("single_time", first_error_time, TS_EN ? 32'd100 : 32'h0);
    chk("single_count", {16'h0, error_event_count}, 32'h1);
    chk("single_irq", {31'h0, irq}, 32'h1);
    // partial then full clear
    clr(16'h0001);
    chk("pclr_sticky", {16'h0, error_sticky}, 32'h0040);
    chk("pclr_irq", {31'h0, irq}, 32'h1);
    chk("pclr_first", {16'h0, first_error}, 32'h0041);
    chk("pclr_time", first_error_time, TS_EN ? 32'd100 : 32'h0);
    clr(16'h0040);
    chk("fclr_sticky", {16'h0, error_sticky}, 32'h0);
    chk("fclr_irq", {31'h0, irq}, 32'h0);
    chk("fclr_first", {16'h0, first_error}, 32'h0);
    chk("fclr_time", first_error_time, 32'h0);
    chk("fclr_count", {16'h0, error_event_count}, 32'h1);
    // masking
    error_mask = 16'h0001;
    ev(16'h0001);
    chk("mask_sticky", {16'h0, error_sticky}, 32'h0);
    chk("mask_count", {16'h0, error_event_count}, 32'h1);
    chk("mask_irq", {31'h0, irq}, 32'h0);
    ev(16'h0003);
    chk("mask2_sticky", {16'h0, error_sticky}, 32'h0002);
    chk("mask2_first", {16'h0, first_error}, 32'h0002);
    chk("mask2_time", first_error_time, TS_EN ? t : 32'h0);
    chk("mask2_count", {16'h0, error_event_count}, 32'h2);
    // full clear zeroes the count
    clr(16'hFFFF);
    chk("cclr_sticky", {16'h0, error_sticky}, 32'h0);
    chk("cclr_count", {16'h0, error_event_count}, 32'h0);
    chk("cclr_irq", {31'h0, irq}, 32'h0);
    // simultaneous clear and set (re-arm)
    error_mask = 16'h0;
    ev(16'h0010);
    chk("pre_first", {16'h0, first_error}, 32'h0010);
    protocol_error = 16'h0200;
    protocol_error_ap_vld = 1'b1;
    clear_bits = 16'hFFFF;
    clear_req = 1'b1;
    t = cyc;
    step();
    chk("rearm_sticky", {16'h0, error_sticky}, 32'h0200);
    chk("rearm_count", {16'h0, error_event_count}, 32'h1);
    chk("rearm_irq", {31'h0, irq}, 32'h1);
    chk("rearm_first", {16'h0, first_error}, 32'h0200);
    chk("rearm_time", first_error_time, TS_EN ? t : 32'h0);
    // later event in LATCHED does not touch first capture
    ev(16'h0004);
    chk("late_sticky", {16'h0, error_sticky}, 32'h0204);
    chk("late_first", {16'h0, first_error}, 32'h0200);
    chk("late_count", {16'h0, error_event_count}, 32'h2);
    // mask change leaves sticky bits alone
    error_mask = 16'hFFFF;
    ev(16'h0800);
    chk("maskchg_sticky", {16'h0, error_sticky}, 32'h0204);
    chk("maskchg_count", {16'h0, error_event_count}, 32'h2);
    error_mask = 16'h0;
    // reset mid-LATCHED with count 5, inputs active during reset
    ev(16'h0001);
    ev(16'h0001);
    ev(16'h0001);
    chk("pre_rst_count", {16'h0, error_event_count}, 32'h5);
    ap_rst = 1'b1;
    protocol_error = 16'h0001;
    protocol_error_ap_vld = 1'b1;
    clear_bits = 16'h0;
    clear_req = 1'b1;
    step();
    all_zero("midrst");
    ap_rst = 1'b0;
    // saturation
    protocol_error = 16'h0001;
    protocol_error_ap_vld = 1'b1;
    repeat (65540) @(posedge ap_clk);
    #1;
    protocol_error_ap_vld = 1'b0;
    chk("sat_count", {16'h0, error_event_count}, 32'hFFFF);
    chk("sat_irq", {31'h0, irq}, 32'h1);
    clr(16'hFFFF);
    chk("satclr_count", {16'h0, error_event_count}, 32'h0);
    chk("satclr_sticky", {16'h0, error_sticky}, 32'h0);
    chk("satclr_irq", {31'h0, irq}, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
